// File: rtl/tt_uio_pkg.sv
// Shared types for the TinyTapeout uio pin controller.
// Command opcodes and command FSM states.
package tt_uio_pkg;

  typedef enum logic [1:0] {
    OP_WR_OE   = 2'd0,
    OP_WR_OUT  = 2'd1,
    OP_RD_IN   = 2'd2,
    OP_RD_EDGE = 2'd3
  } cmd_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

endpackage

// File: rtl/tt_sync_edge.sv
// uio_in synchroniser, prime counter and rising-edge detector.
// Ports: clk, rst, uio_in -> sync_in (synchronised), rise (1-cycle pulses).
module tt_sync_edge #(
  parameter int PIN_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIN_W-1:0] uio_in,
  output logic [PIN_W-1:0] sync_in,
  output logic [PIN_W-1:0] rise
);

  localparam int CNT_W = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0] PRIME_CNT =
    CNT_W'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][PIN_W-1:0] sync_q, sync_d;
  logic [PIN_W-1:0] prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             primed;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = uio_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    sync_in = sync_q[SYNC_STAGES-1];
    prev_d  = sync_in;
    primed  = (cnt_q == PRIME_CNT);
    cnt_d   = primed ? cnt_q : cnt_q + CNT_W'(1);
    // Held off until the chain and prev_q have both
    // filled, so pins high through reset never look
    // like rising edges.
    rise    = primed ? (sync_in & ~prev_q) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/tt_uio_ctrl.sv
// Bidirectional pin controller: owns uio_oe/uio_out, sticky edge flags.
// Ports: clk/rst, uio pads, cmd valid/ready port, rsp valid/ready port.
module tt_uio_ctrl
  import tt_uio_pkg::*;
#(
  parameter int PIN_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIN_W-1:0] uio_in,
  output logic [PIN_W-1:0] uio_out,
  output logic [PIN_W-1:0] uio_oe,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [PIN_W-1:0] cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [PIN_W-1:0] rsp_data
);

  logic [PIN_W-1:0] sync_in;
  logic [PIN_W-1:0] rise;

  tt_sync_edge #(
    .PIN_W      (PIN_W),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .uio_in (uio_in),
    .sync_in(sync_in),
    .rise   (rise)
  );

  state_e           state_q, state_d;
  logic [PIN_W-1:0] oe_q, oe_d;
  logic [PIN_W-1:0] out_q, out_d;
  logic [PIN_W-1:0] flags_q, flags_d;
  logic [PIN_W-1:0] rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic             accept;

  always_comb begin
    state_d  = state_q;
    oe_d     = oe_q;
    out_d    = out_q;
    flags_d  = flags_q | rise;
    rdata_d  = rdata_q;
    rvalid_d = rvalid_q;
    accept   = cmd_valid && (state_q == ST_IDLE);

    if (accept) begin
      unique case (1'b1)
        cmd_op == OP_WR_OE:  oe_d  = cmd_data;
        cmd_op == OP_WR_OUT: out_d = cmd_data;
        cmd_op == OP_RD_IN: begin
          rdata_d  = sync_in;
          rvalid_d = 1'b1;
          state_d  = ST_RESP;
        end
        cmd_op == OP_RD_EDGE: begin
          // Report pre-clear flags; a same-cycle
          // rise survives the clear.
          rdata_d  = flags_q;
          flags_d  = rise;
          rvalid_d = 1'b1;
          state_d  = ST_RESP;
        end
      endcase
    end

    if (state_q == ST_RESP && rsp_ready) begin
      rvalid_d = 1'b0;
      state_d  = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      oe_q     <= '0;
      out_q    <= '0;
      flags_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      oe_q     <= oe_d;
      out_q    <= out_d;
      flags_q  <= flags_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign uio_oe    = oe_q;
  assign uio_out   = out_q;
  assign rsp_data  = rdata_q;
  assign rsp_valid = rvalid_q;
  assign cmd_ready = (state_q == ST_IDLE);

endmodule
